// File: rtl/sr_latch_arbiter_pkg.sv
// Shared state encoding and default sizing for the SR latch arbiter.
package sr_latch_arbiter_pkg;

  localparam int unsigned N_REQ_DEF      = 4;
  localparam int unsigned PULSE_CYC_DEF  = 2;
  localparam int unsigned SETTLE_MAX_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_DONE,
    ST_FAIL
  } state_t;

endpackage

// File: rtl/sr_latch_arbiter_rr_pick.sv
// Combinational round-robin selector: first set req bit at or above rr, wrapping.
module rr_pick
  import sr_latch_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF,
  parameter int unsigned RW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [RW-1:0]    rr,
  output logic [N_REQ-1:0] winner,
  output logic             valid
);

  logic [2*N_REQ-1:0] w_dbl_req;
  logic [2*N_REQ-1:0] w_dbl_oh;
  logic [N_REQ-1:0]   w_rot_req;
  logic [N_REQ-1:0]   w_rot_oh;

  // Rotate so rr lands at bit 0, pick the lowest set bit, rotate the one-hot back.
  always_comb begin
    w_dbl_req = {req, req} >> rr;
    w_rot_req = w_dbl_req[N_REQ-1:0];
    w_rot_oh  = '0;
    valid     = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!valid && w_rot_req[k]) begin
        w_rot_oh[k] = 1'b1;
        valid       = 1'b1;
      end
    end
    w_dbl_oh = {w_rot_oh, w_rot_oh} << rr;
    winner   = w_dbl_oh[2*N_REQ-1:N_REQ];
  end

endmodule

// File: rtl/sr_latch_arbiter.sv
// Round-robin arbiter driving a shared SR latch with pulse/settle/timeout sequencing.
// Optional build macro: SR_LATCH_ARBITER_SKIP_EN (skip drive when latch already matches).
module sr_latch_arbiter
  import sr_latch_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ      = N_REQ_DEF,
  parameter int unsigned PULSE_CYC  = PULSE_CYC_DEF,
  parameter int unsigned SETTLE_MAX = SETTLE_MAX_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] op,
  output logic [N_REQ-1:0] gnt,
  output logic [N_REQ-1:0] done,
  output logic             err,
  input  logic             clr_err,
  output logic             busy,
  output logic             S,
  output logic             R,
  input  logic             Q,
  input  logic             Qbar
);

  localparam int unsigned RW          = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [7:0]  PULSE_C     = 8'(PULSE_CYC);
  localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_MAX - 1);

  state_t           r_state;
  logic [N_REQ-1:0] r_gnt;
  logic [N_REQ-1:0] r_done;
  logic             r_err;
  logic             r_busy;
  logic             r_S;
  logic             r_R;
  logic             r_op;
  logic [RW-1:0]    r_rr;
  logic [7:0]       r_cnt;
  logic             r_armed;

  logic [N_REQ-1:0] w_winner;
  logic             w_valid;
  logic [RW-1:0]    w_win_idx;
  logic [RW-1:0]    w_rr_next;
  logic             w_match;

  rr_pick #(
    .N_REQ (N_REQ),
    .RW    (RW)
  ) u_rr_pick (
    .req    (req),
    .rr     (r_rr),
    .winner (w_winner),
    .valid  (w_valid)
  );

  always_comb begin
    w_win_idx = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (w_winner[k]) w_win_idx = RW'(k);
    end
    w_rr_next = (w_win_idx == RW'(N_REQ - 1)) ? '0 : w_win_idx + 1'b1;
  end

  // Q==Qbar can never satisfy this since r_op and !r_op differ.
  assign w_match = (Q == r_op) && (Qbar == !r_op);

  // r_armed holds off granting until the second edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_gnt   <= '0;
      r_done  <= '0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
      r_S     <= 1'b0;
      r_R     <= 1'b0;
      r_op    <= 1'b0;
      r_rr    <= '0;
      r_cnt   <= '0;
      r_armed <= 1'b0;
    end else begin
      r_armed <= 1'b1;
      if (clr_err) r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_S    <= 1'b0;
          r_R    <= 1'b0;
          r_done <= '0;
          if (r_armed && w_valid) begin
            r_gnt   <= w_winner;
            r_op    <= |(op & w_winner);
            r_rr    <= w_rr_next;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
`ifdef SR_LATCH_ARBITER_SKIP_EN
          if (r_cnt == '0 && w_match) begin
            r_done  <= r_gnt;
            r_state <= ST_DONE;
          end else
`endif
          if (r_cnt < PULSE_C) begin
            r_S   <= r_op;
            r_R   <= !r_op;
            r_cnt <= r_cnt + 8'd1;
          end else begin
            r_S     <= 1'b0;
            r_R     <= 1'b0;
            r_cnt   <= '0;
            r_state <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (w_match) begin
            r_done  <= r_gnt;
            r_state <= ST_DONE;
          end else if (r_cnt == SETTLE_LAST) begin
            r_err   <= 1'b1;
            r_done  <= r_gnt;
            r_state <= ST_FAIL;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        ST_DONE, ST_FAIL: begin
          r_done  <= '0;
          r_gnt   <= '0;
          r_busy  <= 1'b0;
          r_cnt   <= '0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_S     <= 1'b0;
          r_R     <= 1'b0;
          r_done  <= '0;
          r_gnt   <= '0;
          r_busy  <= 1'b0;
          r_cnt   <= '0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign gnt  = r_gnt;
  assign done = r_done;
  assign err  = r_err;
  assign busy = r_busy;
  assign S    = r_S;
  assign R    = r_R;

endmodule
